// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select encodings,
// stall FSM states and default datapath widths.
package pipe_pkg;

    localparam int DW_DEF = 32;
    localparam int CW_DEF = 16;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_mux.sv
// DW-wide 4:1 operand mux selected by a forward-select code.
// Ports: sel, rf/ex/mem/wb candidate values, y selected operand.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    sel,
    input  logic [DW-1:0] rf,
    input  logic [DW-1:0] ex,
    input  logic [DW-1:0] mem,
    input  logic [DW-1:0] wb,
    output logic [DW-1:0] y
);

    always_comb begin
        y = rf;
        unique case (sel)
            FWD_RF:  y = rf;
            FWD_EX:  y = ex;
            FWD_MEM: y = mem;
            FWD_WB:  y = wb;
        endcase
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX register with operand forwarding, load-use stall, memory freeze and flush.
// Ports: ID inputs + forward sources in; PC/IF-ID enables, registered EX bundle, stall count out.
module id_ex_fwd_stage
    import pipe_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int CW       = CW_DEF,
    parameter int LOAD_BIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [DW-1:0]    id_busA,
    input  logic [DW-1:0]    id_busB,
    input  logic [CW-1:0]    id_ctrl,
    input  logic [1:0]       sel_a,
    input  logic [1:0]       sel_b,
    input  logic [DW-1:0]    ex_result,
    input  logic [DW-1:0]    mem_data,
    input  logic [DW-1:0]    wb_data,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             pc_wr_en,
    output logic             ifid_wr_en,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_busA,
    output logic [DW-1:0]    ex_busB,
    output logic [CW-1:0]    ex_ctrl,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e state_q, state_d;

    logic             valid_q, valid_d;
    logic [DW-1:0]    busa_q, busa_d;
    logic [DW-1:0]    busb_q, busb_d;
    logic [CW-1:0]    ctrl_q, ctrl_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DW-1:0] opa, opb;
    logic ex_load, hazard;
    logic en, bubble, load_id, cnt_inc;

    fwd_mux #(.DW(DW)) u_mux_a (
        .sel (sel_a),
        .rf  (id_busA),
        .ex  (ex_result),
        .mem (mem_data),
        .wb  (wb_data),
        .y   (opa)
    );

    fwd_mux #(.DW(DW)) u_mux_b (
        .sel (sel_b),
        .rf  (id_busB),
        .ex  (ex_result),
        .mem (mem_data),
        .wb  (wb_data),
        .y   (opb)
    );

    // Only an EX-stage load cannot be forwarded in time.
    assign ex_load = valid_q & ctrl_q[LOAD_BIT];
    assign hazard  = id_valid & ex_load &
                     ((id_use_rs & (sel_a == FWD_EX)) |
                      (id_use_rt & (sel_b == FWD_EX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!mem_busy) begin
            if (!flush && state_q == RUN && hazard) begin
                state_d = STALL;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        en      = 1'b1;
        bubble  = 1'b0;
        load_id = 1'b0;
        cnt_inc = 1'b0;
        if (mem_busy) begin
            en = 1'b0;
        end else if (flush) begin
            bubble = 1'b1;
        end else if (state_q == RUN && hazard) begin
            en      = 1'b0;
            bubble  = 1'b1;
            cnt_inc = 1'b1;
        end else begin
            load_id = 1'b1;
        end
    end

    assign pc_wr_en   = en & rst_n;
    assign ifid_wr_en = en & rst_n;

    // Bubbles clear the control view of EX; operand buses keep stale data.
    always_comb begin
        valid_d = valid_q;
        busa_d  = busa_q;
        busb_d  = busb_q;
        ctrl_d  = ctrl_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        cnt_d   = cnt_q;
        if (bubble) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rs_d    = '0;
            rt_d    = '0;
        end else if (load_id) begin
            valid_d = id_valid;
            busa_d  = opa;
            busb_d  = opb;
            ctrl_d  = id_ctrl;
            rs_d    = id_rs;
            rt_d    = id_rt;
        end
        if (cnt_inc && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            busa_q  <= '0;
            busb_q  <= '0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            busa_q  <= busa_d;
            busb_q  <= busb_d;
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_busA   = busa_q;
    assign ex_busB   = busb_q;
    assign ex_ctrl   = ctrl_q;
    assign ex_rs     = rs_q;
    assign ex_rt     = rt_q;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/id_ex_fwd_stage.md
# id_ex_fwd_stage

ID/EX pipeline register for the five-stage MIPS pipeline, on the consuming side of the forwarding unit. It takes the 2-bit operand-source selects produced in ID and muxes the register-file or forwarded values into the ID/EX register. It also detects the load-use case that forwarding cannot cover, stalls PC and IF/ID for one cycle, and inserts a bubble. A global memory-wait freeze and a branch flush are honoured with fixed priority.

## Interface
- DW, 32, operand data width
- CW, 16, width of the control bundle carried ID→EX
- LOAD_BIT, 0, index in the control bundle of the "instruction is a load" (MemtoReg) bit
- CNT_W, 16, load-use stall counter width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5  ID source register numbers
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- id_busA, id_busB  in  DW  register-file read data
- id_ctrl  in  CW  decoded control bundle
- sel_a, sel_b  in  2  forward selects: 00 regfile, 01 EX, 10 MEM, 11 WB
- ex_result  in  DW  ALU output of the instruction currently in EX
- mem_data  in  DW  value the MEM-stage instruction will write (load data when load)
- wb_data  in  DW  WB write-back data
- flush  in  1  squash the ID instruction (taken branch/jump)
- mem_busy  in  1  data-memory wait; freeze the pipeline
- pc_wr_en, ifid_wr_en  out  1  PC / IF-ID register write enables (combinational)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_busA, ex_busB  out  DW  registered operands
- ex_ctrl  out  CW  registered control; all-zero on a bubble
- ex_rs, ex_rt  out  5  registered register numbers
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Operand mux, per side: 00→id_bus, 01→ex_result, 10→mem_data, 11→wb_data.
- ex_load = ex_valid & ex_ctrl[LOAD_BIT].
- hazard = id_valid & ex_load & ((id_use_rs & sel_a==01) | (id_use_rt & sel_b==01)).
- FSM has two states, RUN and STALL.
- Per-cycle priority:
  1. mem_busy: pc_wr_en=0, ifid_wr_en=0. All registers, state and counter hold.
  2. flush: ID/EX loads a bubble (ex_valid=0, ex_ctrl=0, ex_rs/rt=0). Both enables are 1. Next state is RUN.
  3. RUN & hazard: both enables are 0. ID/EX loads a bubble. stall_cnt increments, saturating at all-ones. Next state is STALL.
  4. Otherwise: both enables are 1. ID/EX loads the muxed operands, id_ctrl, id_rs/rt, and ex_valid=id_valid. Next state is RUN.
- In STALL, EX holds the bubble, so hazard is 0 by construction. The load is now in MEM, and the forwarding unit supplies sel=10. STALL therefore always completes in one non-frozen cycle.
- While rst_n=0: pc_wr_en=0 and ifid_wr_en=0.

## Timing
- Reset, applied asynchronously: state=RUN, ex_valid=0, ex_busA=ex_busB=0, ex_ctrl=0, ex_rs=ex_rt=0, stall_cnt=0.
- Data latency is one cycle: values presented in ID cycle N appear on ex_* after edge N+1.
- pc_wr_en and ifid_wr_en are combinational in the same cycle as hazard, flush and mem_busy.
- A load-use stall costs exactly one cycle, plus any mem_busy cycles inserted during it.
- Reset asserted in STALL forces RUN immediately. No stall is pending after release.
- flush and hazard together: flush wins, and stall_cnt does not increment.

## Structure
- Package pipe_pkg holds:
  - the forward-select encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB;
  - the state enum {RUN, STALL};
  - the default DW/CW values.
- Sub-module fwd_mux is a DW-wide 4:1 operand mux indexed by a pipe_pkg select, instantiated twice (A and B).

## Test plan
- No hazard: sel_a=00, id_busA=0x11, id_valid=1 → after one edge, ex_busA=0x11, ex_valid=1. Enables stay 1.
- EX forward: EX holds a non-load, sel_b=01, ex_result=0xDEAD → ex_busB=0xDEAD, no stall.
- Load-use sequence:
  - Stimulus: EX holds a load, id_use_rs=1, sel_a=01.
  - Same cycle: pc_wr_en=0, ifid_wr_en=0.
  - Next edge: ex_valid=0, ex_ctrl=0, stall_cnt=1.
  - Following cycle: sel_a=10, mem_data=0x1234 → ex_busA=0x1234, ex_valid=1.
- Flush during a load-use hazard → enables 1, bubble loaded, state RUN, stall_cnt unchanged.
- mem_busy held 3 cycles while in STALL:
  - ex_* and stall_cnt frozen;
  - enables 0 throughout;
  - the stall completes on the first non-busy cycle.
- Reset and saturation:
  - rst_n dropped mid-STALL → all outputs 0 immediately, state RUN.
  - With CNT_W=4, 17 load-use stalls → stall_cnt=15.
